// File: rtl/pmc_digital_conf_shifter_if.sv
`default_nettype none
// ============================================================================
//  Module   : pmc_digital_conf (interface)
//  Brief    : PMC digital configuration word; res[23:0] and th[7:0] form
//             the 32-bit word {res, th} (bit 31 = res[23], bit 0 = th[0]).
//  Revision : 1.0 - initial release
// ============================================================================
interface pmc_digital_conf;
  logic [23:0] res;
  logic [7:0]  th;

  // SoC-side register block drives the word
  modport master (output res, output th);
  // Consumers only observe it
  modport slave  (input res, input th);
endinterface
`default_nettype wire

// File: rtl/pmc_digital_conf_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : pmc_digital_conf_shifter
//  Brief    : Snapshots the 32-bit PMC digital configuration word on start
//             and shifts it MSB first into the pixel-matrix configuration
//             chain once per pixel, then issues a one-cycle parallel load.
//             Each bit occupies two cycles (sh_clk low, then high) so data
//             is stable a full cycle ahead of and through the rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module pmc_digital_conf_shifter #(
  parameter int PIXELS = 16,
  parameter int CNT_W  = $clog2(PIXELS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  pmc_digital_conf.slave   digital_conf,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             sh_clk,
  output logic             sh_dout,
  output logic             sh_load
);

  // Index of the final pixel; reaching its bit 0 ends the shift phase
  localparam logic [CNT_W-1:0] c_last_pix = CNT_W'(PIXELS - 1);
  localparam logic [4:0]       c_last_bit = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Registered state
  state_t            r_state;
  logic [31:0]       r_snapshot;
  logic [31:0]       r_shreg;
  logic [4:0]        r_bit_cnt;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic              r_phase;
  logic              r_busy;
  logic              r_done;
  logic              r_sh_clk;
  logic              r_sh_dout;
  logic              r_sh_load;

  // Next-state values
  state_t            w_state_nxt;
  logic [31:0]       w_snapshot_nxt;
  logic [31:0]       w_shreg_nxt;
  logic [4:0]        w_bit_cnt_nxt;
  logic [CNT_W-1:0]  w_pix_cnt_nxt;
  logic              w_phase_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_sh_clk_nxt;
  logic              w_sh_dout_nxt;
  logic              w_sh_load_nxt;

  // Live configuration word as presented by the register block
  logic [31:0]       w_word;
  assign w_word = {digital_conf.res, digital_conf.th};

  // Outputs come straight from flops so the chain sees glitch-free lines
  assign busy    = r_busy;
  assign done    = r_done;
  assign sh_clk  = r_sh_clk;
  assign sh_dout = r_sh_dout;
  assign sh_load = r_sh_load;

  // State and output register bank with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_snapshot <= '0;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_pix_cnt  <= '0;
      r_phase    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sh_clk   <= 1'b0;
      r_sh_dout  <= 1'b0;
      r_sh_load  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_snapshot <= w_snapshot_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_pix_cnt  <= w_pix_cnt_nxt;
      r_phase    <= w_phase_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_sh_clk   <= w_sh_clk_nxt;
      r_sh_dout  <= w_sh_dout_nxt;
      r_sh_load  <= w_sh_load_nxt;
    end
  end

  // Next-state and next-output logic for the IDLE/SHIFT/LATCH sequencer
  always_comb begin
    w_state_nxt    = r_state;
    w_snapshot_nxt = r_snapshot;
    w_shreg_nxt    = r_shreg;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_pix_cnt_nxt  = r_pix_cnt;
    w_phase_nxt    = r_phase;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_sh_clk_nxt   = r_sh_clk;
    w_sh_dout_nxt  = r_sh_dout;
    w_sh_load_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_busy_nxt    = 1'b0;
        w_sh_clk_nxt  = 1'b0;
        w_sh_dout_nxt = 1'b0;
        // Abort has priority, so a simultaneous start is dropped
        if (start && !abort) begin
          w_snapshot_nxt = w_word;
          w_shreg_nxt    = w_word;
          w_bit_cnt_nxt  = '0;
          w_pix_cnt_nxt  = '0;
          w_phase_nxt    = 1'b0;
          w_busy_nxt     = 1'b1;
          w_sh_dout_nxt  = w_word[31];
          w_state_nxt    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          w_state_nxt   = ST_IDLE;
          w_busy_nxt    = 1'b0;
          w_sh_clk_nxt  = 1'b0;
          w_sh_dout_nxt = 1'b0;
          w_shreg_nxt   = '0;
          w_bit_cnt_nxt = '0;
          w_pix_cnt_nxt = '0;
          w_phase_nxt   = 1'b0;
        end else if (!r_phase) begin
          // Data has been set up for a cycle; raise the chain clock
          w_phase_nxt   = 1'b1;
          w_sh_clk_nxt  = 1'b1;
          w_sh_dout_nxt = r_shreg[31];
        end else begin
          // Bit consumed by the chain; lower the clock and present the next
          w_phase_nxt   = 1'b0;
          w_sh_clk_nxt  = 1'b0;
          w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          if (r_bit_cnt == c_last_bit) begin
            if (r_pix_cnt == c_last_pix) begin
              w_state_nxt   = ST_LATCH;
              w_sh_dout_nxt = 1'b0;
              w_sh_load_nxt = 1'b1;
              w_shreg_nxt   = '0;
              w_pix_cnt_nxt = '0;
            end else begin
              // Next pixel gets the captured word, never the live one
              w_pix_cnt_nxt = r_pix_cnt + CNT_W'(1);
              w_shreg_nxt   = r_snapshot;
              w_sh_dout_nxt = r_snapshot[31];
            end
          end else begin
            w_shreg_nxt   = {r_shreg[30:0], 1'b0};
            w_sh_dout_nxt = r_shreg[30];
          end
        end
      end

      ST_LATCH: begin
        w_state_nxt   = ST_IDLE;
        w_busy_nxt    = 1'b0;
        w_sh_clk_nxt  = 1'b0;
        w_sh_dout_nxt = 1'b0;
        w_bit_cnt_nxt = '0;
        w_pix_cnt_nxt = '0;
        w_phase_nxt   = 1'b0;
        // An abort landing on the load cycle cancels the completion pulse
        w_done_nxt    = !abort;
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_busy_nxt    = 1'b0;
        w_sh_clk_nxt  = 1'b0;
        w_sh_dout_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pmc_digital_conf_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmc_digital_conf_shifter
//  Brief    : Scoreboard bench for pmc_digital_conf_shifter (PIXELS=2).
//             Expected serial bits are queued at start and popped on each
//             observed rising edge of sh_clk.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pmc_digital_conf_shifter;

  localparam int PIXELS   = 2;
  localparam int NBITS    = 32 * PIXELS;
  localparam int BUSY_LEN = 64 * PIXELS + 1;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic start   = 1'b0;
  logic abort   = 1'b0;
  logic busy;
  logic done;
  logic sh_clk;
  logic sh_dout;
  logic sh_load;

  pmc_digital_conf conf_if ();

  pmc_digital_conf_shifter #(
    .PIXELS (PIXELS)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .digital_conf (conf_if),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .sh_clk       (sh_clk),
    .sh_dout      (sh_dout),
    .sh_load      (sh_load)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit q[$];
  bit exp_bit;
  int edge_cnt  = 0;
  int busy_cnt  = 0;
  int load_cnt  = 0;
  int load_pos  = 0;
  int done_cnt  = 0;
  logic prev_clk  = 1'b0;
  logic prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, busy, done, sh_clk, sh_dout, sh_load};
  endfunction

  // Monitor: samples on the falling edge, away from the DUT's active edge
  initial begin
    forever begin
      @(negedge clk);
      if (sh_clk && !prev_clk) begin
        edge_cnt++;
        if (q.size() == 0) begin
          chk("extra_edge", 32'd1, 32'd0);
        end else begin
          exp_bit = q.pop_front();
          chk("bit", {31'd0, sh_dout}, {31'd0, exp_bit});
        end
      end
      if (busy) busy_cnt++;
      if (sh_load) begin
        load_cnt++;
        load_pos = busy_cnt;
      end
      if (done) begin
        done_cnt++;
        chk("done_at_busy_fall", {30'd0, prev_busy, busy}, 32'd2);
      end
      prev_clk  = sh_clk;
      prev_busy = busy;
    end
  end

  task automatic clear_stats();
    edge_cnt = 0;
    busy_cnt = 0;
    load_cnt = 0;
    load_pos = 0;
    done_cnt = 0;
  endtask

  task automatic start_load(input logic [23:0] r, input logic [7:0] t);
    logic [31:0] w;
    w = {r, t};
    @(negedge clk);
    clear_stats();
    q.delete();
    for (int p = 0; p < PIXELS; p++)
      for (int b = 31; b >= 0; b--)
        q.push_back(w[b]);
    conf_if.res = r;
    conf_if.th  = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_full(input string name);
    chk({name, "_edges"},    edge_cnt, NBITS);
    chk({name, "_busy_len"}, busy_cnt, BUSY_LEN);
    chk({name, "_load_cnt"}, load_cnt, 1);
    chk({name, "_load_pos"}, load_pos, BUSY_LEN);
    chk({name, "_done_cnt"}, done_cnt, 1);
    chk({name, "_q_left"},   q.size(), 0);
    repeat (3) @(negedge clk);
    #1;
    chk({name, "_done_once"}, done_cnt, 1);
    chk({name, "_idle"},      outs(), 0);
  endtask

  initial begin
    int n;
    conf_if.res = '0;
    conf_if.th  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a shift
    start_load(24'h123456, 8'h9C);
    repeat (20) @(negedge clk);
    #2;
    chk("pre_rst_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", outs(), 0);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_no_load", load_cnt, 0);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_idle",    outs(), 0);

    // Single load of 0x000001A5
    start_load(24'h000001, 8'hA5);
    wait_done();
    check_full("t1");

    // Snapshot isolation: live th changes mid-load
    start_load(24'h000000, 8'hFF);
    repeat (9) @(negedge clk);
    conf_if.th = 8'h00;
    wait_done();
    check_full("snap");

    // Second start while busy is ignored
    start_load(24'hC35A0F, 8'h81);
    repeat (18) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check_full("busy_start");

    // Abort mid-shift
    start_load(24'hFEDCBA, 8'h98);
    repeat (38) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_outs", outs(), 0);
    q.delete();
    repeat (200) @(negedge clk);
    #1;
    chk("abort_no_load", load_cnt, 0);
    chk("abort_no_done", done_cnt, 0);

    // Fresh load after abort
    start_load(24'h5A5A5A, 8'h3C);
    wait_done();
    check_full("post_abort");

    // Abort and start together in IDLE
    @(negedge clk);
    clear_stats();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_start_busy_cnt", busy_cnt, 0);
    chk("abort_start_idle",     outs(), 0);

    // Abort during the LATCH cycle suppresses done
    start_load(24'h0F0F0F, 8'hF0);
    n = 0;
    while (!sh_load && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("latch_seen", {31'd0, sh_load}, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("latch_abort_no_done", done_cnt, 0);
    chk("latch_abort_load",    load_cnt, 1);
    chk("latch_abort_edges",   edge_cnt, NBITS);
    chk("latch_abort_idle",    outs(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
